// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks.
//   - sc_dec_state_t : stream decoder FSM states
//   - ScOutW/ScWindow: default binary width / window, shared with the SNG blocks
//   - sat_u / sat_s  : saturate a 32-bit value to an unsigned / signed field of
//                      the given width (the caller truncates to that width)
package sc_pkg;

  localparam int unsigned ScOutW   = 8;
  localparam int unsigned ScWindow = 256;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } sc_dec_state_t;

  function automatic logic [31:0] sat_u(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (val > max_v) ? max_v : val;
  endfunction

  function automatic logic signed [31:0] sat_s(input logic signed [31:0] val,
                                               input int unsigned width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end
    return val;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Sample and ones counters for the stochastic stream decoder.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   clr_i         : zero both counters
//   en_i          : count this cycle (one valid stream bit)
//   bit_i         : stream bit
//   ones_next_o   : ones count including the current bit
//   last_sample_o : current enabled bit is the WINDOW-th of the window
module sc_ones_counter #(
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned WINDOW = 256,
  parameter int unsigned SCNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [OUT_W:0]   ones_next_o,
  output logic             last_sample_o
);

  localparam logic [SCNT_W-1:0] LastIdx = SCNT_W'(WINDOW - 1);

  logic [SCNT_W-1:0] sample_cnt_q;
  logic [OUT_W:0]    ones_cnt_q;

  assign ones_next_o   = ones_cnt_q + (OUT_W + 1)'(bit_i);
  assign last_sample_o = en_i && (sample_cnt_q == LastIdx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
    end else if (clr_i) begin
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
    end else if (en_i) begin
      sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
      ones_cnt_q   <= ones_next_o;
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts ones of a unipolar stream over WINDOW
// valid samples and presents the count on a valid/ready output.
// Build option: define SC_DECODE_BIPOLAR_EN to output the saturated
// two's-complement bipolar value 2*ones - WINDOW instead of the unipolar count.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   start_i / abort_i       : begin / discard a conversion
//   bit_in_i / bit_valid_i  : stream bit and its qualifier (used in ACCUM only)
//   result_o / result_valid_o / result_ready_i : result handshake
//   busy_o                  : conversion in progress
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int unsigned OUT_W  = ScOutW,
  parameter int unsigned WINDOW = ScWindow,
  parameter int unsigned SCNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             bit_in_i,
  input  logic             bit_valid_i,
  output logic [OUT_W-1:0] result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             busy_o
);

  sc_dec_state_t    state_q, state_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [OUT_W:0]   ones_next;
  logic             last_sample;
  logic [OUT_W-1:0] result_conv;

  sc_ones_counter #(
    .OUT_W  (OUT_W),
    .WINDOW (WINDOW),
    .SCNT_W (SCNT_W)
  ) u_ones_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (cnt_clr),
    .en_i          (cnt_en),
    .bit_i         (bit_in_i),
    .ones_next_o   (ones_next),
    .last_sample_o (last_sample)
  );

`ifdef SC_DECODE_BIPOLAR_EN
  localparam logic [OUT_W+1:0] WinExt = WINDOW[OUT_W+1:0];
  // 2*ones - WINDOW; the true value always fits OUT_W+2 signed bits.
  logic signed [OUT_W+1:0] bip_diff;
  assign bip_diff    = $signed({ones_next, 1'b0} - WinExt);
  assign result_conv = OUT_W'(sat_s(32'(bip_diff), OUT_W));
`else
  assign result_conv = OUT_W'(sat_u(32'(ones_next), OUT_W));
`endif

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_clr = 1'b1;
          state_d = StAccum;
        end
      end
      StAccum: begin
        cnt_en = bit_valid_i;
        // abort wins over completion of the final bit
        if (abort_i) begin
          state_d = StIdle;
        end else if (last_sample) begin
          result_d       = result_conv;
          result_valid_d = 1'b1;
          state_d        = StHold;
        end
      end
      StHold: begin
        if (result_ready_i) begin
          result_valid_d = 1'b0;
          if (start_i) begin
            cnt_clr = 1'b1;
            state_d = StAccum;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = (state_q == StAccum);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed self-checking bench for sc_stream_decoder (OUT_W=8, WINDOW=256).
// Expected results follow the unipolar or, with SC_DECODE_BIPOLAR_EN, the
// bipolar conversion.
module tb_sc_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ones;
  int prev_res;

  always #5 clk = ~clk;

  sc_stream_decoder u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .abort_i        (abort),
    .bit_in_i       (bit_in),
    .bit_valid_i    (bit_valid),
    .result_o       (result),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .busy_o         (busy)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_res(input int n);
    int v;
`ifdef SC_DECODE_BIPOLAR_EN
    v = 2 * n - 256;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v & 8'hFF;
`else
    v = (n > 255) ? 255 : n;
    return v;
`endif
  endfunction

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  // mode 0: LFSR < 100, 1: first 64 ones, 2: all ones, 3: all zeros, 4: alternating.
  // toggle inserts an invalid cycle (bit_in=1) before every valid bit.
  // abort_at asserts abort together with that valid bit index (-1: never).
  task automatic run_window(input int mode, input bit toggle, input int abort_at,
                            output int n_ones);
    logic [7:0] lfsr;
    logic       b;
    lfsr   = 8'h01;
    n_ones = 0;
    for (int i = 0; i < 256; i++) begin
      if (toggle) begin
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        step();
      end
      case (mode)
        0: begin
          b    = (lfsr < 8'd100);
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        1: b = (i < 64);
        2: b = 1'b1;
        3: b = 1'b0;
        default: b = (i % 2 == 0);
      endcase
      if (i == 255) begin
        check("busy_before_last", 32'(busy), 32'd1);
        check("rv_before_last", 32'(result_valid), 32'd0);
      end
      bit_in    = b;
      bit_valid = 1'b1;
      abort     = (i == abort_at);
      step();
      if (b) n_ones++;
      if (i == abort_at) begin
        abort     = 1'b0;
        bit_valid = 1'b0;
        return;
      end
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_in = 1'b0;
    bit_valid = 1'b0; result_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("reset_result", 32'(result), 32'd0);
    check("reset_rv", 32'(result_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // bit_valid in IDLE is ignored
    bit_valid = 1'b1; bit_in = 1'b1;
    step();
    bit_valid = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);

    // LFSR comparator stream
    do_start();
    check("lfsr_busy", 32'(busy), 32'd1);
    run_window(0, 1'b0, -1, ones);
    check("lfsr_rv", 32'(result_valid), 32'd1);
    check("lfsr_result", 32'(result), 32'(exp_res(ones)));
    check("lfsr_busy_hold", 32'(busy), 32'd0);
    prev_res = exp_res(ones);
    handshake();
    check("hs_rv", 32'(result_valid), 32'd0);
    check("hs_result_kept", 32'(result), 32'(prev_res));

    // valid every other cycle, 64 ones
    do_start();
    run_window(1, 1'b1, -1, ones);
    check("toggle_rv", 32'(result_valid), 32'd1);
`ifdef SC_DECODE_BIPOLAR_EN
    check("toggle_result", 32'(result), 32'h80);
`else
    check("toggle_result", 32'(result), 32'd64);
`endif
    handshake();

    // all ones, then hold with start pulses and no ready
    do_start();
    run_window(2, 1'b0, -1, ones);
`ifdef SC_DECODE_BIPOLAR_EN
    check("ones_result", 32'(result), 32'd127);
`else
    check("ones_result", 32'(result), 32'd255);
`endif
    prev_res = exp_res(ones);
    for (int c = 0; c < 10; c++) begin
      start = (c % 2 == 0);
      step();
      check("hold_rv", 32'(result_valid), 32'd1);
      check("hold_result", 32'(result), 32'(prev_res));
    end
    start = 1'b0;
    check("hold_busy", 32'(busy), 32'd0);

    // ready and start together: straight back into ACCUM
    result_ready = 1'b1; start = 1'b1;
    step();
    result_ready = 1'b0; start = 1'b0;
    check("b2b_rv", 32'(result_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    run_window(3, 1'b0, -1, ones);
`ifdef SC_DECODE_BIPOLAR_EN
    check("zeros_result", 32'(result), 32'h80);
`else
    check("zeros_result", 32'(result), 32'd0);
`endif
    handshake();

    // alternating
    do_start();
    run_window(4, 1'b0, -1, ones);
`ifdef SC_DECODE_BIPOLAR_EN
    check("alt_result", 32'(result), 32'd0);
`else
    check("alt_result", 32'(result), 32'd128);
`endif
    prev_res = exp_res(ones);
    handshake();

    // abort at sample 100
    do_start();
    run_window(2, 1'b0, 100, ones);
    check("abort100_busy", 32'(busy), 32'd0);
    check("abort100_rv", 32'(result_valid), 32'd0);
    check("abort100_result", 32'(result), 32'(prev_res));
    step();
    check("abort100_rv_later", 32'(result_valid), 32'd0);

    // abort on the final bit
    do_start();
    run_window(2, 1'b0, 255, ones);
    check("abortlast_busy", 32'(busy), 32'd0);
    check("abortlast_rv", 32'(result_valid), 32'd0);
    check("abortlast_result", 32'(result), 32'(prev_res));
    step();
    check("abortlast_rv_later", 32'(result_valid), 32'd0);

    // fresh count after aborts, then reset while in HOLD
    do_start();
    run_window(0, 1'b0, -1, ones);
    check("fresh_result", 32'(result), 32'(exp_res(ones)));
    check("fresh_rv", 32'(result_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rsthold_result", 32'(result), 32'd0);
    check("rsthold_rv", 32'(result_valid), 32'd0);
    check("rsthold_busy", 32'(busy), 32'd0);

    // reset mid-ACCUM
    do_start();
    bit_in = 1'b1; bit_valid = 1'b1;
    for (int i = 0; i < 50; i++) step();
    bit_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstacc_busy", 32'(busy), 32'd0);
    check("rstacc_rv", 32'(result_valid), 32'd0);
    check("rstacc_result", 32'(result), 32'd0);

    do_start();
    run_window(4, 1'b0, -1, ones);
    check("post_rst_rv", 32'(result_valid), 32'd1);
    check("post_rst_result", 32'(result), 32'(exp_res(ones)));
    handshake();
    check("post_rst_hs_rv", 32'(result_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
